sub_pipe_chunked: RTL and testbench
===================================

Name: sub_pipe_chunked

Overview:
Pipelined wide-operand subtractor. It is the inverse-direction companion of the registered adder_top benchmark circuit in the arithmetic generated-circuits suite. It computes a - b on ADDER_WIDTH-bit unsigned operands using a chunked borrow chain, with one chunk resolved per pipeline stage. It accepts one operand pair per cycle and targets high Fmax on carry-chain architectures.

Parameters:
ADDER_WIDTH, 122, operand width in bits.
CHUNK_WIDTH, 32, bits resolved per pipeline stage. Must satisfy 1 <= CHUNK_WIDTH <= ADDER_WIDTH.
NUM_STAGES, ceil(ADDER_WIDTH/CHUNK_WIDTH) = 4, derived localparam; not overridable.

Ports:
clk  input  1  single clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair on a/b is valid this cycle.
a  input  ADDER_WIDTH  minuend, unsigned.
b  input  ADDER_WIDTH  subtrahend, unsigned.
out_valid  output  1  out_diff/out_borrow valid this cycle.
out_diff  output  ADDER_WIDTH+1  {borrow, (a-b) mod 2^ADDER_WIDTH}; equals (a-b) mod 2^(ADDER_WIDTH+1).
out_borrow  output  1  1 when a < b. Always equals out_diff[ADDER_WIDTH].

Behaviour:
- Reset: when rst is high at a posedge:
  - out_valid, out_borrow, out_diff <= 0.
  - All stage valid bits <= 0.
  - Data/skew registers need no reset.
- No backpressure. One pair accepted per cycle when in_valid=1. Throughput is 1/cycle.
- Input capture: a, b and in_valid are registered at edge t (input register stage, as in adder_top).
- Stage k (k = 0..NUM_STAGES-1):
  - Computes chunk k = a_chunk - b_chunk - borrow_in(k), where borrow_in(0) = 0 and borrow_in(k) is the registered borrow_out of stage k-1.
  - Registers the chunk result and borrow_out at edge t+1+k.
- Last chunk width = ADDER_WIDTH - (NUM_STAGES-1)*CHUNK_WIDTH; 26 at defaults. Borrow out of the last chunk is the result MSB.
- Operand skew: chunk k operands are delayed k cycles before stage k.
- Result deskew: chunk k results are delayed NUM_STAGES-1-k cycles, so all chunks of one transaction align.
- Output register: loads at edge t+NUM_STAGES+1.
- Latency: in_valid sampled at edge t gives out_valid=1 during the cycle after edge t+NUM_STAGES+1, i.e. 5 edges at defaults.
- Ordering: strictly in-order. Valid bits travel alongside data.
- Bubbles: when in_valid=0, a bubble propagates. out_valid=0 for that slot. out_diff holds its last value (output registers load only on valid).
- Boundaries:
  - a = b gives diff 0, borrow 0.
  - a = 0, b = 1 gives all-ones 123-bit result, borrow 1.
  - a = 2^122-1, b = 0 gives no borrow.
  - Borrow rippling across every chunk boundary must resolve correctly.
- Reset mid-operation: all in-flight transactions are discarded. in_valid during rst is ignored. The first pair sampled on the edge after rst falls is accepted normally, with output NUM_STAGES+1 edges later.
- Degenerate parameters:
  - CHUNK_WIDTH >= ADDER_WIDTH gives NUM_STAGES = 1, latency 2.
  - No combinational path from input to output.

Decomposition:
- Package sub_pipe_pkg:
  - DEFAULT_ADDER_WIDTH (122) and DEFAULT_CHUNK_WIDTH (32).
  - Function num_stages(w, c) = (w+c-1)/c.
  - Function last_chunk_width(w, c).
- Sub-module sub_chunk_stage:
  - Parameter W.
  - Registered W-bit subtract with borrow_in/borrow_out and a valid pass-through.
  - Instantiated NUM_STAGES times via generate; the last instance uses last_chunk_width.
- Skew/deskew: shift registers of parameterised depth in the top level.

Test Plan:
- Reset release, then in_valid=1, a=10, b=3 → out_valid=1 five cycles later, out_diff=7, out_borrow=0. out_valid=0 on all other cycles.
- a=0, b=1 → out_diff=2^123-1 (all 123 bits set), out_borrow=1. Confirms borrow ripples through all 4 chunks.
- Back-to-back stream over 4 cycles with pairs (5,5), (2^32,1), (2^122-1,0), (1,2^121) → four consecutive valid outputs, in order:
  - 0
  - 2^32-1
  - 2^122-1
  - 2^123-2^121+1 with out_borrow=1
- Stream with alternating in_valid 1/0 → out_valid alternates. out_diff holds its value during bubble cycles.
- Issue 3 valid pairs, then assert rst for 1 cycle two edges later → no out_valid for any of them. A new pair sent the edge after reset returns correctly at latency 5.
- Random 10k pairs at CHUNK_WIDTH=32 and CHUNK_WIDTH=122 (NUM_STAGES=1, latency 2) vs a reference model of (a-b) mod 2^123 → zero mismatches.

Source files
------------

// File: rtl/sub_pipe_pkg.sv
// Shared widths and stage-count helpers for the chunked pipelined subtractor.
package sub_pipe_pkg;
  localparam int DEFAULT_ADDER_WIDTH = 122;
  localparam int DEFAULT_CHUNK_WIDTH = 32;

  function automatic int num_stages(input int w, input int c);
    return (w + c - 1) / c;
  endfunction

  // The top chunk takes whatever bits remain after the full-width chunks.
  function automatic int last_chunk_width(input int w, input int c);
    return w - (num_stages(w, c) - 1) * c;
  endfunction
endpackage

// File: rtl/sub_chunk_stage.sv
// One registered W-bit subtract-with-borrow slice; the valid bit rides alongside the data.
module sub_chunk_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic         valid_out,
  output logic [W-1:0] diff,
  output logic         borrow_out
);
  always_ff @(posedge clk) begin
    if (rst) valid_out <= 1'b0;
    else     valid_out <= valid_in;
  end

  // The extra top bit of the (W+1)-bit difference is the borrow out.
  always_ff @(posedge clk) begin
    {borrow_out, diff} <= {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
  end
endmodule

// File: rtl/sub_pipe_chunked.sv
// Pipelined wide subtractor: one borrow-chain chunk per stage, operands skewed in, results deskewed out.
module sub_pipe_chunked
  import sub_pipe_pkg::*;
#(
  parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  output logic                   out_valid,
  output logic [ADDER_WIDTH:0]   out_diff,
  output logic                   out_borrow
);
  localparam int NUM_STAGES = num_stages(ADDER_WIDTH, CHUNK_WIDTH);
  localparam int LAST_W     = last_chunk_width(ADDER_WIDTH, CHUNK_WIDTH);

  logic                   in_vld_q;
  logic [NUM_STAGES:0]    vld_pipe;
  logic [NUM_STAGES:0]    borrow;
  logic [ADDER_WIDTH-1:0] diff_aligned;

  always_ff @(posedge clk) begin
    if (rst) in_vld_q <= 1'b0;
    else     in_vld_q <= in_valid;
  end

  assign vld_pipe[0] = in_vld_q;
  assign borrow[0]   = 1'b0;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_chunk
    localparam int LO  = k * CHUNK_WIDTH;
    localparam int CW  = (k == NUM_STAGES - 1) ? LAST_W : CHUNK_WIDTH;
    localparam int DSK = NUM_STAGES - 1 - k;

    logic [CW-1:0] a_skew [0:k];
    logic [CW-1:0] b_skew [0:k];
    logic [CW-1:0] stage_diff;

    // Element 0 doubles as the input register; chunk k then waits k more cycles
    // so its borrow_in from stage k-1 is ready when its operands arrive.
    always_ff @(posedge clk) begin
      a_skew[0] <= a[LO +: CW];
      b_skew[0] <= b[LO +: CW];
      for (int j = 1; j <= k; j++) begin
        a_skew[j] <= a_skew[j-1];
        b_skew[j] <= b_skew[j-1];
      end
    end

    sub_chunk_stage #(.W(CW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (vld_pipe[k]),
      .a         (a_skew[k]),
      .b         (b_skew[k]),
      .borrow_in (borrow[k]),
      .valid_out (vld_pipe[k+1]),
      .diff      (stage_diff),
      .borrow_out(borrow[k+1])
    );

    if (DSK == 0) begin : g_nodsk
      assign diff_aligned[LO +: CW] = stage_diff;
    end else begin : g_dsk
      logic [CW-1:0] dly [1:DSK];
      always_ff @(posedge clk) begin
        dly[1] <= stage_diff;
        for (int j = 2; j <= DSK; j++) dly[j] <= dly[j-1];
      end
      assign diff_aligned[LO +: CW] = dly[DSK];
    end
  end

  // Output holds its last result through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
    end else begin
      out_valid <= vld_pipe[NUM_STAGES];
      if (vld_pipe[NUM_STAGES]) begin
        out_diff   <= {borrow[NUM_STAGES], diff_aligned};
        out_borrow <= borrow[NUM_STAGES];
      end
    end
  end
endmodule

// File: tb/tb_sub_pipe_chunked.sv
// Bench for sub_pipe_chunked: 4-stage (chunk 32) and 1-stage (chunk 122) instances checked against a latency/arithmetic model.
module tb_sub_pipe_chunked;
  localparam int W  = 122;
  localparam int DW = W + 1;

  logic          clk = 1'b0;
  logic          rst, in_valid;
  logic [W-1:0]  a, b;
  logic          v5, br5, v2, br2;
  logic [DW-1:0] d5, d2;
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  sub_pipe_chunked #(.ADDER_WIDTH(W), .CHUNK_WIDTH(32)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(v5), .out_diff(d5), .out_borrow(br5));

  sub_pipe_chunked #(.ADDER_WIDTH(W), .CHUNK_WIDTH(122)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(v2), .out_diff(d2), .out_borrow(br2));

  // Reference: a pair sampled at edge n-L appears after edge n unless rst was seen on
  // any edge from n-L to n; the result is plain (a-b) mod 2^123 and holds otherwise.
  int            n = 0, last_rst = -1;
  logic          hv [64];
  logic [W-1:0]  ha [64], hb [64];
  logic          ev5 = 1'b0, ev2 = 1'b0;
  logic [DW-1:0] ed5 = '0, ed2 = '0;

  function automatic logic [DW-1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  always @(posedge clk) begin
    ha[n%64] <= a; hb[n%64] <= b; hv[n%64] <= in_valid;
    if (rst) last_rst <= n;
    ev5 <= !rst && n >= 5 && hv[(n-5)%64] && last_rst < n - 5;
    ev2 <= !rst && n >= 2 && hv[(n-2)%64] && last_rst < n - 2;
    if (rst) ed5 <= '0;
    else if (n >= 5 && hv[(n-5)%64] && last_rst < n - 5) ed5 <= ref_sub(ha[(n-5)%64], hb[(n-5)%64]);
    if (rst) ed2 <= '0;
    else if (n >= 2 && hv[(n-2)%64] && last_rst < n - 2) ed2 <= ref_sub(ha[(n-2)%64], hb[(n-2)%64]);
    n <= n + 1;
  end

  function automatic logic [W-1:0] rnd_op();
    logic [127:0] t;
    logic [W-1:0] one;
    int m;
    t   = {$urandom, $urandom, $urandom, $urandom};
    one = {{(W-1){1'b0}}, 1'b1};
    m   = $urandom_range(0, 7);
    if (m == 0) return '0;
    if (m == 1) return '1;
    if (m == 2) return one << $urandom_range(0, W - 1);
    return t[W-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = rnd_op(); b = rnd_op();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (v5 !== 1'b0 || d5 !== '0 || br5 !== 1'b0 || v2 !== 1'b0 || d2 !== '0 || br2 !== 1'b0) begin
        bad++; $display("FAIL reset cyc=%0d got v5=%b d5=%h b5=%b v2=%b d2=%h b2=%b want all zero", i, v5, d5, br5, v2, d2, br2);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (v5 !== ev5 || d5 !== ed5 || v2 !== ev2 || d2 !== ed2) begin
        bad++; $display("FAIL reset_idle cyc=%0d got v5=%b d5=%h v2=%b d2=%h want v5=%b d5=%h v2=%b d2=%h", i, v5, d5, v2, d2, ev5, ed5, ev2, ed2);
      end
    end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; a = W'(10); b = W'(3);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (v5 !== (i == 5) || v2 !== (i == 2)) begin
        bad++; $display("FAIL basic_latency cyc=%0d got v5=%b v2=%b want v5=%b v2=%b", i, v5, v2, i == 5, i == 2);
      end
      if (i == 5) begin
        total++;
        if (d5 !== DW'(7) || br5 !== 1'b0) begin bad++; $display("FAIL basic_c32 got d=%h b=%b want d=7 b=0", d5, br5); end
      end
      if (i == 2) begin
        total++;
        if (d2 !== DW'(7) || br2 !== 1'b0) begin bad++; $display("FAIL basic_c122 got d=%h b=%b want d=7 b=0", d2, br2); end
      end
      total++;
      if (v5 !== ev5 || d5 !== ed5 || br5 !== ed5[W] || v2 !== ev2 || d2 !== ed2 || br2 !== ed2[W]) begin
        bad++; $display("FAIL basic_model cyc=%0d got d5=%h d2=%h want d5=%h d2=%h", i, d5, d2, ed5, ed2);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_borrow_ripple();
    logic [DW-1:0] ones;
    ones = '1;
    in_valid = 1'b1; a = '0; b = W'(1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 5) begin
        total++;
        if (v5 !== 1'b1 || d5 !== ones || br5 !== 1'b1) begin bad++; $display("FAIL ripple_c32 got v=%b d=%h b=%b want v=1 d=%h b=1", v5, d5, br5, ones); end
      end
      if (i == 2) begin
        total++;
        if (v2 !== 1'b1 || d2 !== ones || br2 !== 1'b1) begin bad++; $display("FAIL ripple_c122 got v=%b d=%h b=%b want v=1 d=%h b=1", v2, d2, br2, ones); end
      end
      total++;
      if (v5 !== ev5 || d5 !== ed5 || br5 !== ed5[W] || v2 !== ev2 || d2 !== ed2 || br2 !== ed2[W]) begin
        bad++; $display("FAIL ripple_model cyc=%0d got d5=%h d2=%h want d5=%h d2=%h", i, d5, d2, ed5, ed2);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  pa [4], pb [4];
    logic [DW-1:0] want [4];
    logic [W-1:0]  one;
    one = {{(W-1){1'b0}}, 1'b1};
    pa[0] = W'(5);      pb[0] = W'(5);
    pa[1] = one << 32;  pb[1] = one;
    pa[2] = '1;         pb[2] = '0;
    pa[3] = one;        pb[3] = one << 121;
    want[0] = '0;
    want[1] = {91'd0, 32'hFFFF_FFFF};
    want[2] = {1'b0, {W{1'b1}}};
    want[3] = {2'b11, 121'd0} + DW'(1);
    in_valid = 1'b1; a = pa[0]; b = pb[0];
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (v5 !== (i >= 5 && i <= 8) || v2 !== (i >= 2 && i <= 5)) begin
        bad++; $display("FAIL b2b_valid cyc=%0d got v5=%b v2=%b", i, v5, v2);
      end
      if (i >= 5 && i <= 8) begin
        total++;
        if (d5 !== want[i-5] || br5 !== want[i-5][W]) begin bad++; $display("FAIL b2b_c32 idx=%0d got d=%h b=%b want d=%h", i - 5, d5, br5, want[i-5]); end
      end
      if (i >= 2 && i <= 5) begin
        total++;
        if (d2 !== want[i-2] || br2 !== want[i-2][W]) begin bad++; $display("FAIL b2b_c122 idx=%0d got d=%h b=%b want d=%h", i - 2, d2, br2, want[i-2]); end
      end
      if (i < 3) begin a = pa[i+1]; b = pb[i+1]; end
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_bubbles();
    logic [DW-1:0] prev5;
    prev5 = d5;
    in_valid = 1'b1; a = rnd_op(); b = rnd_op();
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (v5 !== (i >= 5 && i < 15 && (i - 5) % 2 == 0)) begin bad++; $display("FAIL bubble_valid cyc=%0d got v5=%b", i, v5); end
      if (i >= 5 && !v5) begin
        total++;
        if (d5 !== prev5) begin bad++; $display("FAIL bubble_hold cyc=%0d got d=%h want d=%h", i, d5, prev5); end
      end
      total++;
      if (v5 !== ev5 || d5 !== ed5 || br5 !== ed5[W] || v2 !== ev2 || d2 !== ed2 || br2 !== ed2[W]) begin
        bad++; $display("FAIL bubble_model cyc=%0d got d5=%h d2=%h want d5=%h d2=%h", i, d5, d2, ed5, ed2);
      end
      prev5 = d5;
      in_valid = (i + 1 < 10) && ((i + 1) % 2 == 0);
      a = rnd_op(); b = rnd_op();
    end
  endtask

  task automatic test_reset_mid();
    // edges 0..2 issue pairs, edge 4 resets (with in_valid high), edge 5 issues 100-58
    rst = 1'b0; in_valid = 1'b1; a = rnd_op(); b = rnd_op();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (v5 !== (i == 10) || v2 !== (i == 2 || i == 3 || i == 7)) begin
        bad++; $display("FAIL rstmid_valid cyc=%0d got v5=%b v2=%b", i, v5, v2);
      end
      if (i == 10) begin
        total++;
        if (d5 !== DW'(42) || br5 !== 1'b0) begin bad++; $display("FAIL rstmid_c32 got d=%h want d=42", d5); end
      end
      if (i == 7) begin
        total++;
        if (d2 !== DW'(42) || br2 !== 1'b0) begin bad++; $display("FAIL rstmid_c122 got d=%h want d=42", d2); end
      end
      total++;
      if (v5 !== ev5 || d5 !== ed5 || br5 !== ed5[W] || v2 !== ev2 || d2 !== ed2 || br2 !== ed2[W]) begin
        bad++; $display("FAIL rstmid_model cyc=%0d got d5=%h d2=%h want d5=%h d2=%h", i, d5, d2, ed5, ed2);
      end
      rst      = (i + 1 == 4);
      in_valid = (i + 1 <= 2) || (i + 1 == 4) || (i + 1 == 5);
      a = (i + 1 == 5) ? W'(100) : rnd_op();
      b = (i + 1 == 5) ? W'(58)  : rnd_op();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10010; i++) begin
      in_valid = (i < 10000) && ($urandom_range(0, 9) != 0);
      a = rnd_op();
      b = ($urandom_range(0, 7) == 0) ? a : rnd_op();
      @(posedge clk); @(negedge clk);
      total++;
      if (v5 !== ev5 || d5 !== ed5 || br5 !== ed5[W]) begin
        bad++; $display("FAIL random_c32 cyc=%0d got v=%b d=%h b=%b want v=%b d=%h", i, v5, d5, br5, ev5, ed5);
      end
      total++;
      if (v2 !== ev2 || d2 !== ed2 || br2 !== ed2[W]) begin
        bad++; $display("FAIL random_c122 cyc=%0d got v=%b d=%h b=%b want v=%b d=%h", i, v2, d2, br2, ev2, ed2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_back_to_back();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
